// File: rtl/cache_fill_engine.sv
// Miss fill: latch miss, pick victim way, fetch line over req/gnt + beat-valid, stream bytes; min 3+BLOCK_BYTES cycles.
// Waits on mem_gnt/mem_rvalid indefinitely unless FILL_TIMEOUT_EN is defined (15-cycle stall -> ERROR pulse).
module cache_fill_engine #(
    parameter int ADDRESS_WORD_SIZE = 32,
    parameter int OFFSET_BITS       = 2
) (
    input  logic                         clk,
    input  logic                         rst_b,
    input  logic                         miss_req,
    input  logic [ADDRESS_WORD_SIZE-1:0] miss_addr,
    input  logic [3:0]                   set_valid,
    input  logic [7:0]                   set_ages,
    output logic                         mem_req,
    output logic [ADDRESS_WORD_SIZE-1:0] mem_addr,
    input  logic                         mem_gnt,
    input  logic                         mem_rvalid,
    input  logic [7:0]                   mem_rdata,
    output logic                         fill_we,
    output logic [3:0]                   fill_way,
    output logic [OFFSET_BITS-1:0]       fill_offset,
    output logic [7:0]                   fill_data,
    output logic                         fill_tag_we,
    output logic                         fill_done,
    output logic                         fill_error,
    output logic                         busy
);
    typedef enum logic [2:0] {
        IDLE, SELECT, REQ, FILL, DONE
`ifdef FILL_TIMEOUT_EN
        , ERROR
`endif
    } state_t;

    state_t                         state_q, state_d;
    logic [ADDRESS_WORD_SIZE-1:0]   addr_q, addr_d;
    logic [3:0]                     valid_q, valid_d;
    logic [7:0]                     ages_q, ages_d;
    logic [OFFSET_BITS-1:0]         cnt_q, cnt_d;
    logic [3:0]                     fill_way_q, fill_way_d;
    logic                           fill_we_q, fill_we_d;
    logic [OFFSET_BITS-1:0]         fill_offset_q, fill_offset_d;
    logic [7:0]                     fill_data_q, fill_data_d;
    logic                           mem_req_q, mem_req_d;
    logic                           busy_q, busy_d;
    logic                           fill_done_q, fill_done_d;
    logic                           fill_tag_we_q, fill_tag_we_d;
    logic [3:0]                     victim;
    logic [1:0]                     best_age;
    logic                           found_inv;
    logic                           miss_addr_lsb_unused;
`ifdef FILL_TIMEOUT_EN
    logic [3:0]                     stall_q, stall_d;
    logic                           fill_error_q, fill_error_d;
`endif

    assign miss_addr_lsb_unused = ^miss_addr[OFFSET_BITS-1:0];

    // Invalid ways win first; otherwise oldest age, strict compare keeps the lowest index on ties.
    always_comb begin
        victim    = 4'b0000;
        best_age  = 2'd0;
        found_inv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!valid_q[i] && !found_inv) begin
                victim    = 4'b0000;
                victim[i] = 1'b1;
                found_inv = 1'b1;
            end
        end
        if (!found_inv) begin
            victim   = 4'b0001;
            best_age = ages_q[1:0];
            for (int i = 1; i < 4; i++) begin
                if (ages_q[2*i +: 2] > best_age) begin
                    best_age  = ages_q[2*i +: 2];
                    victim    = 4'b0000;
                    victim[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        valid_d       = valid_q;
        ages_d        = ages_q;
        cnt_d         = cnt_q;
        fill_way_d    = fill_way_q;
        fill_we_d     = 1'b0;
        fill_offset_d = fill_offset_q;
        fill_data_d   = fill_data_q;
        case (state_q)
            IDLE: begin
                if (miss_req) begin
                    addr_d  = {miss_addr[ADDRESS_WORD_SIZE-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                    valid_d = set_valid;
                    ages_d  = set_ages;
                    state_d = SELECT;
                end
            end
            SELECT: begin
                fill_way_d = victim;
                state_d    = REQ;
            end
            REQ: begin
                if (mem_gnt) begin
                    cnt_d   = '0;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (mem_rvalid) begin
                    fill_we_d     = 1'b1;
                    fill_data_d   = mem_rdata;
                    fill_offset_d = cnt_q;
                    cnt_d         = cnt_q + 1'b1;
                    if (&cnt_q) state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef FILL_TIMEOUT_EN
        // Counter restarts on any state change and on forward progress in REQ/FILL.
        if (state_d != state_q || !(state_q == REQ || state_q == FILL)) begin
            stall_d = 4'd0;
        end else if ((state_q == REQ && mem_gnt) || (state_q == FILL && mem_rvalid)) begin
            stall_d = 4'd0;
        end else begin
            stall_d = stall_q + 4'd1;
        end
        if (stall_d == 4'd15) begin
            state_d = ERROR;
            stall_d = 4'd0;
        end
        fill_error_d = (state_d == ERROR);
`endif

        mem_req_d     = (state_d == REQ);
        busy_d        = (state_d != IDLE);
        fill_done_d   = (state_d == DONE);
        fill_tag_we_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            valid_q       <= '0;
            ages_q        <= '0;
            cnt_q         <= '0;
            fill_way_q    <= '0;
            fill_we_q     <= 1'b0;
            fill_offset_q <= '0;
            fill_data_q   <= '0;
            mem_req_q     <= 1'b0;
            busy_q        <= 1'b0;
            fill_done_q   <= 1'b0;
            fill_tag_we_q <= 1'b0;
`ifdef FILL_TIMEOUT_EN
            stall_q       <= '0;
            fill_error_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            valid_q       <= valid_d;
            ages_q        <= ages_d;
            cnt_q         <= cnt_d;
            fill_way_q    <= fill_way_d;
            fill_we_q     <= fill_we_d;
            fill_offset_q <= fill_offset_d;
            fill_data_q   <= fill_data_d;
            mem_req_q     <= mem_req_d;
            busy_q        <= busy_d;
            fill_done_q   <= fill_done_d;
            fill_tag_we_q <= fill_tag_we_d;
`ifdef FILL_TIMEOUT_EN
            stall_q       <= stall_d;
            fill_error_q  <= fill_error_d;
`endif
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = addr_q;
    assign fill_we     = fill_we_q;
    assign fill_way    = fill_way_q;
    assign fill_offset = fill_offset_q;
    assign fill_data   = fill_data_q;
    assign fill_tag_we = fill_tag_we_q;
    assign fill_done   = fill_done_q;
    assign busy        = busy_q;
`ifdef FILL_TIMEOUT_EN
    assign fill_error  = fill_error_q;
`else
    assign fill_error  = 1'b0;
`endif

endmodule

// File: tb/tb_cache_fill_engine.sv
// Bench for cache_fill_engine: table vectors, random misses against a line-level model, reset/timeout sequences.
module tb_cache_fill_engine;
    localparam int AW = 32;
    localparam int OB = 2;
    localparam int NB = 1 << OB;

    logic          clk = 1'b0;
    logic          rst_b;
    logic          miss_req;
    logic [AW-1:0] miss_addr;
    logic [3:0]    set_valid;
    logic [7:0]    set_ages;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [7:0]    mem_rdata;
    logic          fill_we;
    logic [3:0]    fill_way;
    logic [OB-1:0] fill_offset;
    logic [7:0]    fill_data;
    logic          fill_tag_we;
    logic          fill_done;
    logic          fill_error;
    logic          busy;

    cache_fill_engine #(.ADDRESS_WORD_SIZE(AW), .OFFSET_BITS(OB)) dut (
        .clk(clk), .rst_b(rst_b), .miss_req(miss_req), .miss_addr(miss_addr),
        .set_valid(set_valid), .set_ages(set_ages), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .fill_we(fill_we), .fill_way(fill_way), .fill_offset(fill_offset),
        .fill_data(fill_data), .fill_tag_we(fill_tag_we), .fill_done(fill_done),
        .fill_error(fill_error), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [3:0]    valid;
        logic [7:0]    ages;
        logic [3:0]    exp_way;
        int            gnt_dly;
        logic [7:0]    gaps;
        logic          stray;
        logic          inject;
    } vec_t;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    int            n_done, n_done_bad, n_err, done_cyc;
    logic [OB+7:0] got_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_obs();
        got_q.delete();
        n_done = 0; n_done_bad = 0; n_err = 0; done_cyc = 0;
    endtask

    // One clock; observe registered outputs 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (fill_we) got_q.push_back({fill_offset, fill_data});
        if (fill_done) begin
            n_done++;
            done_cyc = cyc;
            if (!fill_tag_we || !fill_we) n_done_bad++;
        end
        if (fill_error) n_err++;
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({mem_req, mem_addr, fill_we, fill_way, fill_offset, fill_data,
                    fill_tag_we, fill_done, fill_error, busy});
    endfunction

    // Victim = lowest invalid way; else the lowest way holding the largest age.
    function automatic logic [3:0] model_victim(input logic [3:0] v, input logic [7:0] a);
        int maxage = 0;
        for (int i = 0; i < 4; i++) if (v[i] == 1'b0) return 4'(1 << i);
        for (int i = 0; i < 4; i++) if (int'(a[2*i +: 2]) > maxage) maxage = int'(a[2*i +: 2]);
        for (int i = 0; i < 4; i++) if (int'(a[2*i +: 2]) == maxage) return 4'(1 << i);
        return 4'b0000;
    endfunction

    task automatic run_miss(input string tag, input vec_t v, input logic [31:0] beats);
        logic [AW-1:0] exp_addr;
        int addr_bad = 0;
        int busy_bad = 0;
        int data_bad = 0;
        int start, exp_lat;
        exp_addr = {v.addr[AW-1:OB], {OB{1'b0}}};
        exp_lat  = 3 + NB + v.gnt_dly;
        for (int b = 0; b < NB; b++) exp_lat += int'(v.gaps[2*b +: 2]);
        clear_obs();
        start     = cyc;
        miss_req  = 1'b1;
        miss_addr = v.addr;
        set_valid = v.valid;
        set_ages  = v.ages;
        step();
        miss_req  = 1'b0;
        miss_addr = $urandom;
        set_valid = 4'($urandom);
        set_ages  = 8'($urandom);
        step();
        check({tag, " way"}, 64'(fill_way), 64'(v.exp_way));
        check({tag, " mem_addr"}, 64'(mem_addr), 64'(exp_addr));
        check({tag, " mem_req"}, 64'(mem_req), 64'd1);
        for (int c = 0; c < v.gnt_dly; c++) begin
            mem_rvalid = v.stray;
            mem_rdata  = 8'hEE;
            step();
            if (mem_req !== 1'b1 || mem_addr !== exp_addr) addr_bad++;
        end
        mem_gnt    = 1'b1;
        mem_rvalid = v.stray;
        mem_rdata  = 8'hEE;
        step();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        for (int b = 0; b < NB; b++) begin
            for (int g = 0; g < int'(v.gaps[2*b +: 2]); g++) begin
                step();
                if (busy !== 1'b1) busy_bad++;
            end
            mem_rvalid = 1'b1;
            mem_rdata  = beats[8*b +: 8];
            if (v.inject && b == 1) begin
                miss_req  = 1'b1;
                miss_addr = ~v.addr;
                set_valid = 4'b0000;
            end
            step();
            miss_req   = 1'b0;
            mem_rvalid = 1'b0;
            if (busy !== 1'b1) busy_bad++;
        end
        step();
        check({tag, " busy_end"}, 64'(busy), 64'd0);
        check({tag, " n_we"}, 64'(got_q.size()), 64'(NB));
        for (int i = 0; i < NB && i < got_q.size(); i++)
            if (got_q[i] !== {OB'(i), beats[8*i +: 8]}) data_bad++;
        check({tag, " we_data"}, 64'(data_bad), 64'd0);
        check({tag, " n_done"}, 64'(n_done), 64'd1);
        check({tag, " done_with_we_tag"}, 64'(n_done_bad), 64'd0);
        check({tag, " latency"}, 64'(done_cyc - start), 64'(exp_lat));
        check({tag, " req_stable"}, 64'(addr_bad), 64'd0);
        check({tag, " busy_hold"}, 64'(busy_bad), 64'd0);
        check({tag, " way_held"}, 64'(fill_way), 64'(v.exp_way));
        check({tag, " addr_held"}, 64'(mem_addr), 64'(exp_addr));
        check({tag, " no_error"}, 64'(n_err), 64'd0);
    endtask

    vec_t tbl[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t rv;
        rst_b = 1'b0; miss_req = 1'b0; miss_addr = '0; set_valid = '0; set_ages = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        clear_obs();
        #1;
        check("reset_outputs", all_outs(), 64'd0);
        step(); step();
        rst_b = 1'b1;
        step();

        //          addr           valid    ages          way      dly gaps         stray inject
        tbl[0] = '{32'h1234_5677, 4'b1011, 8'h00,        4'b0100, 0, 8'h00,        1'b0, 1'b0};
        tbl[1] = '{32'hA5A5_0003, 4'hF,    8'b01_11_00_10, 4'b0100, 5, 8'b11_10_01_00, 1'b1, 1'b0};
        tbl[2] = '{32'h0000_0001, 4'hF,    8'b11_00_11_00, 4'b0010, 0, 8'h00,        1'b0, 1'b0};
        tbl[3] = '{32'hFFFF_FFFF, 4'b0000, 8'h5A,        4'b0001, 1, 8'b00_00_11_00, 1'b0, 1'b0};
        tbl[4] = '{32'h8000_0002, 4'b0111, 8'h00,        4'b1000, 2, 8'b01_01_01_01, 1'b0, 1'b1};
        tbl[5] = '{32'h0000_0000, 4'hF,    8'h00,        4'b0001, 0, 8'h00,        1'b0, 1'b0};
        tbl[6] = '{32'h1357_9BDF, 4'hF,    8'hFF,        4'b0001, 3, 8'h00,        1'b1, 1'b0};
        tbl[7] = '{32'h2468_ACE1, 4'b1110, 8'hC3,        4'b0001, 0, 8'b10_00_00_01, 1'b0, 1'b0};
        for (int t = 0; t < 8; t++) run_miss($sformatf("vec%0d", t), tbl[t], 32'hDDCC_BBAA);

        for (int r = 0; r < 30; r++) begin
            rv.addr    = $urandom;
            rv.valid   = 4'($urandom);
            rv.ages    = 8'($urandom);
            rv.exp_way = model_victim(rv.valid, rv.ages);
            rv.gnt_dly = int'($urandom_range(0, 5));
            rv.gaps    = 8'($urandom);
            rv.stray   = 1'($urandom);
            rv.inject  = 1'($urandom);
            run_miss($sformatf("rnd%0d", r), rv, $urandom);
        end

        // Reset after two beats: everything clears at once, no completion.
        clear_obs();
        miss_req = 1'b1; miss_addr = 32'hCAFE_F00D; set_valid = 4'b1011; set_ages = 8'h00;
        step();
        miss_req = 1'b0;
        step();
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        for (int b = 0; b < 2; b++) begin
            mem_rvalid = 1'b1; mem_rdata = 8'(8'h10 + b);
            step();
        end
        mem_rvalid = 1'b0;
        rst_b = 1'b0;
        #1;
        check("rst_mid_outputs", all_outs(), 64'd0);
        step(); step();
        check("rst_mid_partial_we", 64'(got_q.size()), 64'd2);
        check("rst_mid_no_done", 64'(n_done), 64'd0);
        rst_b = 1'b1;
        step();
        run_miss("after_rst", tbl[0], 32'h4433_2211);

        // Beats withheld after grant.
        clear_obs();
        miss_req = 1'b1; miss_addr = 32'h0000_1000; set_valid = 4'hF; set_ages = 8'h1B;
        step();
        miss_req = 1'b0;
        step();
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        for (int c = 0; c < 20; c++) step();
        check("stall_no_done", 64'(n_done), 64'd0);
`ifdef FILL_TIMEOUT_EN
        check("stall_error_pulse", 64'(n_err), 64'd1);
        check("stall_idle", 64'(busy), 64'd0);
`else
        check("stall_no_error", 64'(n_err), 64'd0);
        check("stall_busy", 64'(busy), 64'd1);
`endif
        rst_b = 1'b0;
        step();
        rst_b = 1'b1;
        step();
        run_miss("after_stall", tbl[2], 32'h0102_0304);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
